// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock through a single corrected digit cell.
// Optional nines'-complement subtraction (port sub) when BCD_SERIAL_SUBTRACT_EN is defined.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                c_in,
`ifdef BCD_SERIAL_SUBTRACT_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                c_out,
  output logic                invalid
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic            carry_q, carry_d;
  logic            inv_q, inv_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            invalid_q, invalid_d;

  logic            sub_in;
  logic [3:0]      ad, bd, bd_eff, digit;
  logic [4:0]      t, t6;
  logic            carry_nx, inv_nx;
  logic [W+3:0]    work_cat;
  logic [W-1:0]    work_nx;

`ifdef BCD_SERIAL_SUBTRACT_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Operands shift right each digit, so the cell always reads the low nibble.
  always_comb begin
    ad       = a_q[3:0];
    bd       = b_q[3:0];
    bd_eff   = sub_q ? (4'd9 - bd) : bd;
    t        = {1'b0, ad} + {1'b0, bd_eff} + {4'b0, carry_q};
    t6       = t + 5'd6;
    carry_nx = (t > 5'd9);
    digit    = carry_nx ? t6[3:0] : t[3:0];
    inv_nx   = inv_q | (ad > 4'd9) | (bd > 4'd9);
    work_cat = {digit, work_q};
    work_nx  = work_cat[W+3:4];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    carry_d   = carry_q;
    inv_d     = inv_q;
    sub_d     = sub_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          carry_d = sub_in ? 1'b1 : c_in;
          idx_d   = '0;
          work_d  = '0;
          inv_d   = 1'b0;
        end
      end
      ADD: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = carry_nx;
        work_d  = work_nx;
        inv_d   = inv_nx;
        idx_d   = idx_q + IDXW'(1);
        // Result registers load on the edge into DONE so done and sum appear together.
        if (idx_q == LAST) begin
          state_d   = DONE;
          sum_d     = work_nx;
          cout_d    = carry_nx;
          invalid_d = inv_nx;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      carry_q   <= 1'b0;
      inv_q     <= 1'b0;
      sub_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      carry_q   <= carry_d;
      inv_q     <= inv_d;
      sub_q     <= sub_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign c_out   = cout_q;
  assign invalid = invalid_q;

endmodule
